alu_control_seq: RTL and testbench

Parametrised successor to the combinational ALU control decoder. Decodes the 3-bit ALU class from the main control unit plus the 6-bit function field into a registered 4-bit ALU operation and 2-bit jump control (one ID→EX pipeline stage). Adds shift/compare/XOR/JALR decode and a multi-cycle sequencer for MULT/MULTU/DIV/DIVU that stalls the front end and strobes the HI/LO write.

---
 rtl/alu_ctl_pkg.sv | 69 ++++++
 rtl/alu_control_seq_md_sequencer.sv | 55 +++++
 rtl/alu_control_seq.sv | 121 ++++++++++++
 tb/tb_alu_control_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_pkg.sv
// Shared codes for the ALU control decoder and mul/div sequencer.
// Function fields, ALU classes, operation/jump/md codes, FSM state type.
package alu_ctl_pkg;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] CLS_ANDI  = 3'b001;
  localparam logic [2:0] CLS_BR    = 3'b010;
  localparam logic [2:0] CLS_MEM   = 3'b011;
  localparam logic [2:0] CLS_ADDI  = 3'b100;
  localparam logic [2:0] CLS_ORI   = 3'b101;
  localparam logic [2:0] CLS_LUI   = 3'b110;
  localparam logic [2:0] CLS_RTYPE = 3'b111;

  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1001;
  localparam logic [3:0] OP_JR   = OP_NOP;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JR   = 2'b10;
  localparam logic [1:0] JMP_JALR = 2'b11;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] jmp;
    logic       is_md;
    logic [1:0] md_op;
  } dec_t;

  function automatic logic md_is_div(input logic [1:0] md_op);
    return md_op[1];
  endfunction

endpackage

// File: rtl/alu_control_seq_md_sequencer.sv
// Mul/div occupancy FSM: down-counts the unit latency, stalls the
// front end and strobes the HI/LO write on the last busy cycle.
module md_sequencer
  import alu_ctl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic flush_i,
  output logic stall_o,
  output logic hilo_we_o
);

  localparam int MAXL = (MUL_LATENCY > DIV_LATENCY) ?
                        MUL_LATENCY : DIV_LATENCY;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  md_state_e     state;
  logic [CW-1:0] cnt;
  logic          last;

  assign last      = (cnt == '0);
  assign stall_o   = (state == MD_BUSY) && !last;
  assign hilo_we_o = (state == MD_BUSY) && last && !flush_i;

  // start can only arrive while idle or on the final busy cycle,
  // since any earlier busy cycle holds the instruction in ID.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else if (flush_i) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else if (start) begin
      state <= MD_BUSY;
      cnt   <= is_div ? DIV_LOAD : MUL_LOAD;
    end else if (state == MD_BUSY) begin
      if (last) begin
        state <= MD_IDLE;
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// ID->EX ALU control stage: decodes class/function into a registered
// ALU operation and jump control, and launches multi-cycle mul/div.
module alu_control_seq
  import alu_ctl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic       flush_i,
  input  logic [2:0] alu_op_i,
  input  logic [5:0] alu_function_i,
  output logic [3:0] alu_operation_o,
  output logic [1:0] jmp_ctl_o,
  output logic       valid_o,
  output logic       md_start_o,
  output logic [1:0] md_op_o,
  output logic       stall_o,
  output logic       hilo_we_o
);

  dec_t dec;
  logic accept;
  logic md_go;

  always_comb begin
    dec       = '0;
    dec.op    = OP_NOP;
    dec.jmp   = JMP_NONE;
    dec.md_op = MD_MULT;
    case (alu_op_i)
      CLS_ADDI: dec.op = OP_ADD;
      CLS_ORI:  dec.op = OP_OR;
      CLS_ANDI: dec.op = OP_AND;
      CLS_LUI:  dec.op = OP_LUI;
      CLS_MEM:  dec.op = OP_ADD;
      CLS_BR:   dec.op = OP_SUB;
      CLS_RTYPE: begin
        case (alu_function_i)
          FN_ADD: dec.op = OP_ADD;
          FN_SUB: dec.op = OP_SUB;
          FN_AND: dec.op = OP_AND;
          FN_OR:  dec.op = OP_OR;
          FN_NOR: dec.op = OP_NOR;
          FN_XOR: dec.op = OP_XOR;
          FN_SLL: dec.op = OP_SLL;
          FN_SRL: dec.op = OP_SRL;
          FN_SLT: dec.op = OP_SLT;
          FN_JR: begin
            dec.op  = OP_JR;
            dec.jmp = JMP_JR;
          end
          FN_JALR: begin
            dec.op  = OP_ADD;
            dec.jmp = JMP_JALR;
          end
          FN_MULT: begin
            dec.op    = OP_MUL;
            dec.is_md = 1'b1;
            dec.md_op = MD_MULT;
          end
          FN_MULTU: begin
            dec.op    = OP_MUL;
            dec.is_md = 1'b1;
            dec.md_op = MD_MULTU;
          end
          FN_DIV: begin
            dec.op    = OP_DIV;
            dec.is_md = 1'b1;
            dec.md_op = MD_DIV;
          end
          FN_DIVU: begin
            dec.op    = OP_DIV;
            dec.is_md = 1'b1;
            dec.md_op = MD_DIVU;
          end
          default: dec.op = OP_NOP;
        endcase
      end
      default: dec.op = OP_NOP;
    endcase
  end

  assign accept = valid_i && !stall_o && !flush_i;
  assign md_go  = accept && dec.is_md;

  // Non-accepting edges (idle, stall, flush) emit a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_operation_o <= OP_NOP;
      jmp_ctl_o       <= JMP_NONE;
      valid_o         <= 1'b0;
      md_start_o      <= 1'b0;
      md_op_o         <= MD_MULT;
    end else begin
      alu_operation_o <= accept ? dec.op : OP_NOP;
      jmp_ctl_o       <= accept ? dec.jmp : JMP_NONE;
      valid_o         <= accept;
      md_start_o      <= md_go;
      if (md_go) begin
        md_op_o <= dec.md_op;
      end
    end
  end

  md_sequencer #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (md_go),
    .is_div    (md_is_div(dec.md_op)),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .hilo_we_o (hilo_we_o)
  );

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, mul/div occupancy,
// flush and reset behaviour, plus a MUL_LATENCY=1 instance.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [2:0] alu_op_i = '0;
  logic [5:0] alu_function_i = '0;

  logic [3:0] op;
  logic [1:0] jmp;
  logic       vo, mds, stall, hwe;
  logic [1:0] mdop;

  logic [3:0] op1;
  logic [1:0] jmp1;
  logic       vo1, mds1, stall1, hwe1;
  logic [1:0] mdop1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_control_seq #(.MUL_LATENCY(4), .DIV_LATENCY(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
    .alu_op_i(alu_op_i), .alu_function_i(alu_function_i),
    .alu_operation_o(op), .jmp_ctl_o(jmp), .valid_o(vo),
    .md_start_o(mds), .md_op_o(mdop), .stall_o(stall),
    .hilo_we_o(hwe)
  );

  alu_control_seq #(.MUL_LATENCY(1), .DIV_LATENCY(32)) dut1 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
    .alu_op_i(alu_op_i), .alu_function_i(alu_function_i),
    .alu_operation_o(op1), .jmp_ctl_o(jmp1), .valid_o(vo1),
    .md_start_o(mds1), .md_op_o(mdop1), .stall_o(stall1),
    .hilo_we_o(hwe1)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c,
                       input logic [5:0] f);
    valid_i        = v;
    alu_op_i       = c;
    alu_function_i = f;
  endtask

  typedef struct {
    logic [2:0] c;
    logic [5:0] f;
    logic [3:0] op;
    logic [1:0] j;
  } vec_t;

  vec_t vecs[11] = '{
    '{3'b111, 6'b100000, 4'b0011, 2'b00},
    '{3'b101, 6'b000000, 4'b0010, 2'b00},
    '{3'b111, 6'b001000, 4'b1001, 2'b10},
    '{3'b111, 6'b101010, 4'b1100, 2'b00},
    '{3'b111, 6'b111111, 4'b1001, 2'b00},
    '{3'b111, 6'b001001, 4'b0011, 2'b11},
    '{3'b111, 6'b100110, 4'b1101, 2'b00},
    '{3'b110, 6'b000000, 4'b0101, 2'b00},
    '{3'b010, 6'b000000, 4'b0100, 2'b00},
    '{3'b111, 6'b000010, 4'b1011, 2'b00},
    '{3'b000, 6'b100000, 4'b1001, 2'b00}
  };

  logic bad;

  initial begin
    #12;
    check("rst_op", op, 8'h9);
    check("rst_jmp", jmp, 8'h0);
    check("rst_valid", vo, 8'h0);
    check("rst_mds", mds, 8'h0);
    check("rst_stall", stall, 8'h0);
    check("rst_hwe", hwe, 8'h0);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].c, vecs[i].f);
      tick();
      check($sformatf("dec_op%0d", i), op, 8'(vecs[i].op));
      check($sformatf("dec_jmp%0d", i), jmp, 8'(vecs[i].j));
      check($sformatf("dec_v%0d", i), vo, 8'h1);
    end
    drive(1'b0, 3'b111, 6'b100000);
    tick();
    check("bubble_op", op, 8'h9);
    check("bubble_v", vo, 8'h0);

    // MULT, latency 4, ADD held behind it
    drive(1'b1, 3'b111, 6'b011000);
    tick();
    check("mul_c1_mds", mds, 8'h1);
    check("mul_c1_mdop", mdop, 8'h0);
    check("mul_c1_op", op, 8'he);
    check("mul_c1_stall", stall, 8'h1);
    check("mul_c1_hwe", hwe, 8'h0);
    drive(1'b1, 3'b111, 6'b100000);
    tick();
    check("mul_c2_mds", mds, 8'h0);
    check("mul_c2_stall", stall, 8'h1);
    check("mul_c2_v", vo, 8'h0);
    check("mul_c2_op", op, 8'h9);
    tick();
    check("mul_c3_stall", stall, 8'h1);
    check("mul_c3_hwe", hwe, 8'h0);
    tick();
    check("mul_c4_stall", stall, 8'h0);
    check("mul_c4_hwe", hwe, 8'h1);
    tick();
    check("mul_c5_op", op, 8'h3);
    check("mul_c5_v", vo, 8'h1);
    check("mul_c5_hwe", hwe, 8'h0);
    drive(1'b0, 3'b000, 6'b000000);
    tick();

    // DIVU then MULT accepted on the cnt==0 edge
    drive(1'b1, 3'b111, 6'b011011);
    tick();
    check("divu_c1_mds", mds, 8'h1);
    check("divu_c1_mdop", mdop, 8'h3);
    check("divu_c1_op", op, 8'hf);
    drive(1'b1, 3'b111, 6'b011000);
    bad = 1'b0;
    for (int c = 2; c <= 31; c++) begin
      tick();
      if (stall !== 1'b1 || hwe !== 1'b0 || mdop !== 2'b11) bad = 1'b1;
    end
    check("divu_busy", bad, 8'h0);
    tick();
    check("divu_c32_hwe", hwe, 8'h1);
    check("divu_c32_stall", stall, 8'h0);
    tick();
    check("b2b_c33_mds", mds, 8'h1);
    check("b2b_c33_mdop", mdop, 8'h0);
    check("b2b_c33_stall", stall, 8'h1);
    check("b2b_c33_hwe", hwe, 8'h0);
    drive(1'b0, 3'b000, 6'b000000);
    repeat (3) tick();
    check("b2b_c36_hwe", hwe, 8'h1);
    tick();

    // flush in cycle 10 of a DIV
    drive(1'b1, 3'b111, 6'b011010);
    tick();
    check("div_c1_mdop", mdop, 8'h2);
    drive(1'b0, 3'b000, 6'b000000);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_stall", stall, 8'h0);
    check("flush_v", vo, 8'h0);
    check("flush_hwe", hwe, 8'h0);
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (hwe !== 1'b0 || stall !== 1'b0) bad = 1'b1;
    end
    check("flush_no_hwe", bad, 8'h0);
    drive(1'b1, 3'b111, 6'b100000);
    tick();
    check("flush_idle_op", op, 8'h3);
    drive(1'b0, 3'b000, 6'b000000);
    tick();

    // flush coinciding with cnt==0 gates the strobe
    drive(1'b1, 3'b111, 6'b011000);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    repeat (3) tick();
    check("fz_hwe_pre", hwe, 8'h1);
    flush_i = 1'b1;
    #1;
    check("fz_hwe_gated", hwe, 8'h0);
    tick();
    flush_i = 1'b0;
    check("fz_stall", stall, 8'h0);
    check("fz_hwe", hwe, 8'h0);
    check("fz_mds", mds, 8'h0);

    // reset in the middle of a DIV
    drive(1'b1, 3'b111, 6'b011010);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("mrst_op", op, 8'h9);
    check("mrst_mdop", mdop, 8'h0);
    check("mrst_stall", stall, 8'h0);
    check("mrst_hwe", hwe, 8'h0);
    check("mrst_v", vo, 8'h0);
    @(negedge clk);
    reset = 1'b1;

    // MUL_LATENCY=1 instance, back-to-back MULT
    drive(1'b1, 3'b111, 6'b011000);
    tick();
    check("l1_c1_mds", mds1, 8'h1);
    check("l1_c1_hwe", hwe1, 8'h1);
    check("l1_c1_stall", stall1, 8'h0);
    tick();
    check("l1_c2_mds", mds1, 8'h1);
    check("l1_c2_hwe", hwe1, 8'h1);
    check("l1_c2_stall", stall1, 8'h0);
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    check("l1_c3_mds", mds1, 8'h0);
    check("l1_c3_hwe", hwe1, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
